// File: rtl/koggestone_sub_pipe_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone subtractor.
// Stage vectors are sized for the widest supported operand; unused upper bits stay zero.
package koggestone_pkg;

  localparam int KS_DEFAULT_LEV = 4;
  localparam int KS_MAX_LEV     = 6;
  localparam int KS_MAX_W       = 1 << KS_MAX_LEV;

  typedef logic [KS_MAX_W-1:0] ks_vec_t;

  typedef struct packed {
    ks_vec_t p;
    ks_vec_t g;
    ks_vec_t p0;
    logic    sa;
    logic    sb;
  } ks_stage_t;

  function automatic int ks_width(input int lev);
    return 1 << lev;
  endfunction

  // Ones in the low ks_width(lev) bits; shifting out of range wraps to all ones.
  function automatic ks_vec_t ks_mask(input int lev);
    ks_vec_t one;
    one = ks_vec_t'(1);
    return (one << ks_width(lev)) - one;
  endfunction

endpackage

// File: rtl/koggestone_sub_pipe_if.sv
// Operand/result handshake bundle for koggestone_sub_pipe.
// The ovf signal exists only when KOGGESTONE_SUB_OVERFLOW_EN is defined.
interface koggestone_sub_pipe_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef KOGGESTONE_SUB_OVERFLOW_EN
  logic         ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, ovf
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
  );
`endif
endinterface

// File: rtl/koggestone_sub_pipe_level.sv
// One registered Kogge-Stone prefix level (level K of LEV), stalled by the shared enable.
// p0 and the sign bits ride through untouched.
module koggestone_sub_level
  import koggestone_pkg::*;
#(
  parameter int LEV = KS_DEFAULT_LEV,
  parameter int K   = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  logic      valid_i,
  input  ks_stage_t stage_i,
  output logic      valid_o,
  output ks_stage_t stage_o
);

  localparam int      S    = 1 << (K - 1);
  localparam ks_vec_t MASK = ks_mask(LEV);

  logic      valid_q;
  ks_stage_t stage_q;
  ks_stage_t stage_d;

  always_comb begin
    stage_d   = stage_i;
    stage_d.g = (stage_i.g | (stage_i.p & (stage_i.g << S))) & MASK;
    stage_d.p = (stage_i.p & (stage_i.p << S)) & MASK;
  end

  // Only the valid bit is reset; data is qualified by it downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (en) begin
      valid_q <= valid_i;
    end
    if (en) begin
      stage_q <= stage_d;
    end
  end

  assign valid_o = valid_q;
  assign stage_o = stage_q;

endmodule

// File: rtl/koggestone_sub_pipe.sv
// Pipelined Kogge-Stone subtractor: diff = a - b, borrow = a < b, LEV+1 register stages.
// Define KOGGESTONE_SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module koggestone_sub_pipe
  import koggestone_pkg::*;
#(
  parameter int LEV = KS_DEFAULT_LEV
) (
  input logic                 clk,
  input logic                 rst,
  koggestone_sub_pipe_if.slave bus
);

  localparam int W = ks_width(LEV);

  logic         en;
  logic         valid_w [LEV+1];
  ks_stage_t    stage_w [LEV+1];

  logic         s0_valid_q;
  ks_stage_t    s0_q;
  ks_stage_t    s0_d;
  logic [W-1:0] p_w;
  logic [W-1:0] g_w;

  // a + ~b + 1: the carry-in is folded into g[0], p0 keeps the unfolded propagate.
  always_comb begin
    p_w    = bus.a ^ ~bus.b;
    g_w    = bus.a & ~bus.b;
    g_w[0] = g_w[0] | p_w[0];
    s0_d   = '0;
    s0_d.p[W-1:0]  = p_w;
    s0_d.p0[W-1:0] = p_w;
    s0_d.g[W-1:0]  = g_w;
`ifdef KOGGESTONE_SUB_OVERFLOW_EN
    s0_d.sa = bus.a[W-1];
    s0_d.sb = bus.b[W-1];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
    end else if (en) begin
      s0_valid_q <= bus.in_valid;
    end
    if (en) begin
      s0_q <= s0_d;
    end
  end

  assign valid_w[0] = s0_valid_q;
  assign stage_w[0] = s0_q;

  genvar gi;
  generate
    for (gi = 1; gi <= LEV; gi++) begin : g_level
      koggestone_sub_level #(
        .LEV (LEV),
        .K   (gi)
      ) u_level (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .valid_i (valid_w[gi-1]),
        .stage_i (stage_w[gi-1]),
        .valid_o (valid_w[gi]),
        .stage_o (stage_w[gi])
      );
    end
  endgenerate

  ks_stage_t last_w;
  ks_vec_t   diff_full_w;
  logic      unused_stage;

  assign last_w      = stage_w[LEV];
  assign diff_full_w = last_w.p0 ^ {last_w.g[KS_MAX_W-2:0], 1'b1};

  // Whole pipe advances together; a full pipe still accepts when the head leaves.
  assign en            = ~valid_w[LEV] | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = valid_w[LEV];
  assign bus.diff      = diff_full_w[W-1:0];
  assign bus.borrow    = ~last_w.g[W-1];

`ifdef KOGGESTONE_SUB_OVERFLOW_EN
  assign bus.ovf = (last_w.sa ^ last_w.sb) & (last_w.sa ^ diff_full_w[W-1]);
`endif

  assign unused_stage = ^{last_w.p, last_w.g, diff_full_w, last_w.sa, last_w.sb};

endmodule

// File: tb/tb_koggestone_sub_pipe.sv
// Directed self-checking bench for koggestone_sub_pipe (LEV=4, 16-bit operands).
module tb_koggestone_sub_pipe;

  localparam int LEV = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  koggestone_sub_pipe_if #(.W(16)) bus ();

  koggestone_sub_pipe #(.LEV(LEV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        b;
    logic        o;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        head;
  logic [15:0] cur_d;
  logic        cur_b;
  logic        cur_o;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: handshakes are sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'd1, 32'd0);
        end else begin
          head = exp_q.pop_front();
          chk("diff", 32'(bus.diff), 32'(head.d));
          chk("borrow", 32'(bus.borrow), 32'(head.b));
`ifdef KOGGESTONE_SUB_OVERFLOW_EN
          chk("ovf", 32'(bus.ovf), 32'(head.o));
`endif
          $display("out diff=0x%04h borrow=%0b exp_diff=0x%04h exp_borrow=%0b",
                   bus.diff, bus.borrow, head.d, head.b);
        end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        exp_q.push_back('{cur_d, cur_b, cur_o});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves in_valid high on return so back-to-back sends stay back-to-back.
  task automatic send(input logic [15:0] a_v, input logic [15:0] b_v, input logic [15:0] d_v,
                      input logic bo_v, input logic ov_v, output int tries);
    logic acc;
    acc          = 1'b0;
    tries        = 0;
    bus.a        = a_v;
    bus.b        = b_v;
    bus.in_valid = 1'b1;
    cur_d        = d_v;
    cur_b        = bo_v;
    cur_o        = ov_v;
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = (bus.in_ready === 1'b1);
      step();
      tries++;
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid === 1'b1) && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Directed corner vectors: a, b, diff, borrow, ovf (hand-computed).
  localparam int NV = 7;
  logic [15:0] va  [NV] = '{16'h0000, 16'h1234, 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h00FF};
  logic [15:0] vb  [NV] = '{16'h0001, 16'h1234, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFF, 16'h0100};
  logic [15:0] vd  [NV] = '{16'hFFFF, 16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF};
  logic        vbo [NV] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        vov [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int          tries;
    logic [15:0] ai;
    logic [15:0] bi;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    cur_d         = '0;
    cur_b         = 1'b0;
    cur_o         = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Latency: accepted beat shows up LEV+1 edges later.
    send(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, tries);
    bus.in_valid = 1'b0;
    chk("lat_early", 32'(bus.out_valid), 32'd0);
    repeat (LEV - 1) begin
      step();
      chk("lat_early", 32'(bus.out_valid), 32'd0);
    end
    step();
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_diff", 32'(bus.diff), 32'h0002);
    chk("lat_borrow", 32'(bus.borrow), 32'd0);
    wait_drain();

    for (int i = 0; i < NV; i++) begin
      send(va[i], vb[i], vd[i], vbo[i], vov[i], tries);
    end
    bus.in_valid = 1'b0;
    wait_drain();

    // Back-to-back: (i - 2i) mod 2^16, borrow whenever i > 0.
    for (int i = 0; i < 16; i++) begin
      ai = 16'(i);
      bi = 16'(2 * i);
      send(ai, bi, 16'(16'h0000 - ai), (i != 0), 1'b0, tries);
      chk("b2b_ready", 32'(tries), 32'd1);
    end
    bus.in_valid = 1'b0;
    wait_drain();

    // Fill with out_ready low, hold a pending beat, then release.
    bus.out_ready = 1'b0;
    for (int i = 0; i < LEV + 1; i++) begin
      send(16'(16'h0100 + 16'(i * 16'h11)), 16'(i), 16'(16'h0100 + 16'(i * 16'h10)), 1'b0, 1'b0, tries);
      chk("fill_ready", 32'(tries), 32'd1);
    end
    bus.a        = 16'h0200;
    bus.b        = 16'h0001;
    cur_d        = 16'h01FF;
    cur_b        = 1'b0;
    cur_o        = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_diff", 32'(bus.diff), 32'h0100);
      chk("stall_borrow", 32'(bus.borrow), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    send(16'h0200, 16'h0001, 16'h01FF, 1'b0, 1'b0, tries);
    bus.in_valid = 1'b0;
    wait_drain();

    // Reset with beats in flight: nothing may emerge afterwards.
    for (int i = 0; i < 3; i++) begin
      send(16'(16'h0300 + 16'(i)), 16'h0000, 16'(16'h0300 + 16'(i)), 1'b0, 1'b0, tries);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst2_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (LEV + 1) begin
      step();
      chk("rst2_quiet", 32'(bus.out_valid), 32'd0);
    end
    send(16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, tries);
    bus.in_valid = 1'b0;
    wait_drain();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
